// File: rtl/ram_burst_reader.sv
// rtl/ram_burst_reader.sv - burst read initiator for one dual-port RAM port.
// Issues credit-limited reads and streams returned words with a last marker.
module ram_burst_reader #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 14,
  parameter int RAM_DEPTH  = 4096,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  input  logic                  ram_dout_valid,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);

  localparam int CW = LEN_WIDTH + 1;
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  if (RD_LATENCY < 1 || FIFO_DEPTH < 2) begin : g_bad_params
    $error("ram_burst_reader: RD_LATENCY must be >= 1 and FIFO_DEPTH >= 2");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [CW-1:0]         issue_cnt;
  logic [CW-1:0]         ret_cnt;
  logic [OW-1:0]         outstanding;
  logic [OW-1:0]         fifo_count;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic                  fifo_last [FIFO_DEPTH];

  logic          cmd_fire;
  logic          ret_ok;
  logic          pop;
  logic          credit_ok;
  logic [OW:0]   credit_sum;

  // Credit counts both in-flight reads and buffered words so a return always has a slot.
  assign credit_sum = {1'b0, outstanding} + {1'b0, fifo_count};
  assign credit_ok  = credit_sum < (OW+1)'(FIFO_DEPTH);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign ret_ok     = ram_dout_valid && (outstanding != '0);
  assign m_valid    = (fifo_count != '0);
  assign pop        = m_valid && m_ready;
  assign m_data     = m_valid ? fifo_data[rd_ptr] : '0;
  assign m_last     = m_valid && fifo_last[rd_ptr];
  assign ram_we     = 1'b0;
  assign ram_addr   = addr_q;
  assign busy       = (state != IDLE);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    ram_en    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (credit_ok) begin
          ram_en = 1'b1;
          if (issue_cnt == {1'b0, len_q}) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      issue_cnt   <= '0;
      ret_cnt     <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state <= state_nxt;
      if (cmd_fire) begin
        addr_q    <= cmd_addr;
        len_q     <= cmd_len;
        issue_cnt <= '0;
        ret_cnt   <= '0;
      end else begin
        if (ram_en) begin
          addr_q    <= (addr_q == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
          issue_cnt <= issue_cnt + CW'(1);
        end
        if (ret_ok) ret_cnt <= ret_cnt + CW'(1);
      end
      case ({ram_en, ret_ok})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
      case ({ret_ok, pop})
        2'b10:   fifo_count <= fifo_count + OW'(1);
        2'b01:   fifo_count <= fifo_count - OW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (ret_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (ret_ok) begin
      fifo_data[wr_ptr] <= ram_dout;
      fifo_last[wr_ptr] <= (ret_cnt == {1'b0, len_q});
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(ret_ok && !pop && fifo_count == OW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_ram_burst_reader.sv
// tb/tb_ram_burst_reader.sv - scoreboard bench for ram_burst_reader with a 2-cycle RAM model.
module tb_ram_burst_reader;
  localparam int DW = 36;
  localparam int AW = 14;
  localparam int LW = 16;
  localparam int DEPTH = 4096;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout;
  logic          ram_dout_valid;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;

  ram_burst_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH),
    .RD_LATENCY(2), .FIFO_DEPTH(4), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .ram_dout_valid(ram_dout_valid),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy)
  );

  initial forever #5 clk = ~clk;

  // RAM model: one output pipe stage plus the array read, not cleared by rst_n.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] p0_d = '0, p1_d = '0;
  logic          p0_v = 1'b0, p1_v = 1'b0;
  always @(posedge clk) begin
    p0_v <= ram_en;
    p0_d <= mem[ram_addr[11:0]];
    p1_v <= p0_v;
    p1_d <= p0_d;
  end
  assign ram_dout       = p1_d;
  assign ram_dout_valid = p1_v;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW:0] exp_q [$];
  int          addr_q [$];
  int inflight, issued_total, pop_cnt, acc_cyc;
  int first_en, last_en, first_pop, last_pop;
  logic hold_pend, post_last, held_last;
  logic [DW-1:0] held_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic push_burst(input int addr, input int len);
    for (int i = 0; i <= len; i++) begin
      int a;
      a = (addr + i) % DEPTH;
      exp_q.push_back({mem[a], (i == len)});
      addr_q.push_back(a);
    end
  endtask

  task automatic clear_marks();
    first_en = -1; last_en = -1; first_pop = -1;
    issued_total = 0; pop_cnt = 0;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        addr_q.delete();
        inflight = 0; hold_pend = 0; post_last = 0;
      end else begin
        if (post_last) begin
          check("idle_busy", busy, 0);
          check("idle_cmd_ready", cmd_ready, 1);
          post_last = 0;
        end
        if (hold_pend) begin
          check("hold_valid", m_valid, 1);
          check("hold_data", m_data, held_data);
          check("hold_last", m_last, held_last);
        end
        if (ram_en) begin
          check("ram_we", ram_we, 0);
          if (addr_q.size() == 0) check("addr_extra", 1, 0);
          else check("ram_addr", ram_addr, addr_q.pop_front());
          inflight++;
          check("credit", inflight <= 4, 1);
          issued_total++;
          if (first_en < 0) first_en = cyc;
          last_en = cyc;
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) check("pop_extra", 1, 0);
          else begin
            logic [DW:0] e;
            e = exp_q.pop_front();
            check("m_data", m_data, e[DW:1]);
            check("m_last", m_last, e[0]);
          end
          inflight--;
          pop_cnt++;
          if (first_pop < 0) first_pop = cyc;
          if (m_last) begin last_pop = cyc; post_last = 1; end
        end
        hold_pend = m_valid && !m_ready;
        held_data = m_data;
        held_last = m_last;
      end
    end
  endtask

  task automatic send_cmd(input int addr, input int len, input bit keep);
    bit ok;
    ok = 0;
    cmd_addr = AW'(addr);
    cmd_len = LW'(len);
    cmd_valid = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc_cyc = cyc;
        push_burst(addr, len);
        ok = 1;
        break;
      end
    end
    if (!ok) check("cmd_accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input bit toggle);
    bit ok;
    ok = 0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      if (toggle) m_ready = ~m_ready;
      if (exp_q.size() == 0 && !busy) begin ok = 1; break; end
    end
    if (!ok) check("drain_timeout", 0, 1);
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_ready = 1'b1;
    last_pop = -1;
    clear_marks();
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i) * 36'd2654435 + 36'h7_0000_0001;
    mem[5] = 36'hA5;
    for (int i = 0; i < 8; i++) mem[16 + i] = DW'(i);
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single word latency
    clear_marks();
    send_cmd(5, 0, 0);
    wait_done(0);
    check("single_en_lat", first_en - acc_cyc, 1);
    check("single_pop_lat", first_pop - acc_cyc, 4);
    check("single_pops", pop_cnt, 1);

    // Full rate
    clear_marks();
    send_cmd(16, 7, 0);
    wait_done(0);
    check("full_en_span", last_en - first_en, 7);
    check("full_pop_span", last_pop - first_pop, 7);
    check("full_pops", pop_cnt, 8);

    // Backpressure
    clear_marks();
    m_ready = 1'b0;
    send_cmd(512, 15, 0);
    repeat (9) @(posedge clk);
    #1;
    check("bp_issued_stalled", issued_total, 4);
    wait_done(1);
    check("bp_pops", pop_cnt, 16);

    // Address wrap
    clear_marks();
    send_cmd(4094, 3, 0);
    wait_done(0);
    check("wrap_pops", pop_cnt, 4);

    // Reset mid-burst
    clear_marks();
    send_cmd(768, 31, 0);
    for (int k = 0; k < 50 && issued_total < 5; k++) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_ram_en", ram_en, 0);
    check("mid_rst_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_m_valid", m_valid, 0);
    check("post_rst_busy", busy, 0);
    @(posedge clk); #1;
    clear_marks();
    send_cmd(256, 1, 0);
    wait_done(0);
    check("post_rst_pops", pop_cnt, 2);

    // Back-to-back commands with cmd_valid held
    clear_marks();
    send_cmd(1000, 3, 1);
    send_cmd(2000, 2, 0);
    check("b2b_accept", acc_cyc, last_pop + 1);
    wait_done(0);
    check("b2b_pops", pop_cnt, 7);

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
